// File: rtl/booth_pkg.sv
// Shared types and default widths for the Booth multiplier issue/collect sequencer.
// Used by the RTL and by benches that build operand records.
package booth_pkg;

    localparam int X_DEF     = 32;
    localparam int Y_DEF     = 32;
    localparam int TAG_W_DEF = 4;
    localparam int WD_MARGIN = 16;

    typedef enum logic [2:0] {
        RST_MUL,
        IDLE,
        LOAD,
        WAIT_LO,
        WAIT_HI
    } issue_state_t;

    typedef struct packed {
        logic [X_DEF-1:0]     m;
        logic [Y_DEF-1:0]     r;
        logic [TAG_W_DEF-1:0] tag;
    } booth_op_t;

endpackage

// File: rtl/booth_issue_if.sv
// Bundle of the operand stream, result stream and multiplier-side signals of booth_issue.
// slave is the sequencer's view; master is the view of whoever surrounds it.
interface booth_issue_if #(
    parameter int X     = 32,
    parameter int Y     = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [X-1:0]     in_m;
    logic [Y-1:0]     in_r;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [X+Y-1:0]   out_product;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    logic [X-1:0]     mul_m;
    logic [Y-1:0]     mul_r;
    logic             mul_load;
    logic             mul_reset;
    logic [X+Y-1:0]   mul_product;
    logic             mul_done;

    logic             busy;

    modport slave (
        input  in_valid, in_m, in_r, in_tag, out_ready, mul_product, mul_done,
        output in_ready, out_valid, out_product, out_tag, out_err,
        output mul_m, mul_r, mul_load, mul_reset, busy
    );

    modport master (
        output in_valid, in_m, in_r, in_tag, out_ready, mul_product, mul_done,
        input  in_ready, out_valid, out_product, out_tag, out_err,
        input  mul_m, mul_r, mul_load, mul_reset, busy
    );

endinterface

// File: rtl/booth_op_fifo.sv
// Small operand FIFO: register-array storage, combinational head read,
// read/write pointers carrying an extra wrap bit to tell full from empty.
module booth_op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/booth_issue.sv
// Issue/collect sequencer around a Booth FSM multiplier: queues tagged operands,
// launches one multiplication at a time, returns tagged products, recovers from hangs.
module booth_issue
    import booth_pkg::*;
#(
    parameter int X      = X_DEF,
    parameter int Y      = Y_DEF,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int WD_CYC = Y + WD_MARGIN
) (
    input  logic         clk,
    input  logic         reset,
    booth_issue_if.slave bus
);
    localparam int WD_W = $clog2(WD_CYC + 1);
    localparam int OP_W = X + Y + TAG_W;

    typedef struct packed {
        logic [X-1:0]     m;
        logic [Y-1:0]     r;
        logic [TAG_W-1:0] tag;
    } op_t;

    issue_state_t     state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [X-1:0]     mul_m_q, mul_m_d;
    logic [Y-1:0]     mul_r_q, mul_r_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic             out_err_q, out_err_d;
    logic [X+Y-1:0]   out_product_q, out_product_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    op_t              push_op, pop_op;
    logic [OP_W-1:0]  pop_raw;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic             out_free, wd_expired;

    assign push_op   = '{m: bus.in_m, r: bus.in_r, tag: bus.in_tag};
    assign pop_op    = op_t'(pop_raw);
    assign fifo_push = bus.in_valid && !fifo_full;

    booth_op_fifo #(
        .DEPTH (DEPTH),
        .W     (OP_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_op),
        .pop       (fifo_pop),
        .pop_data  (pop_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_free   = !out_valid_q || bus.out_ready;
    assign wd_expired = (wd_q == WD_W'(WD_CYC));

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        mul_m_d       = mul_m_q;
        mul_r_d       = mul_r_q;
        tag_d         = tag_q;
        out_valid_d   = out_valid_q;
        out_err_d     = out_err_q;
        out_product_d = out_product_q;
        out_tag_d     = out_tag_q;
        fifo_pop      = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            RST_MUL: begin
                state_d = IDLE;
            end
            IDLE: begin
                // Only launch when the result slot is guaranteed free at completion.
                if (!fifo_empty && out_free) begin
                    fifo_pop = 1'b1;
                    mul_m_d  = pop_op.m;
                    mul_r_d  = pop_op.r;
                    tag_d    = pop_op.tag;
                    wd_d     = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                // done is still high from the previous operation; wait for it to drop.
                wd_d = wd_q + 1'b1;
                if (!bus.mul_done) begin
                    state_d = WAIT_HI;
                end else if (wd_expired) begin
                    out_valid_d   = 1'b1;
                    out_err_d     = 1'b1;
                    out_product_d = '0;
                    out_tag_d     = tag_q;
                    state_d       = RST_MUL;
                end
            end
            WAIT_HI: begin
                wd_d = wd_q + 1'b1;
                if (bus.mul_done) begin
                    out_valid_d   = 1'b1;
                    out_err_d     = 1'b0;
                    out_product_d = bus.mul_product;
                    out_tag_d     = tag_q;
                    state_d       = IDLE;
                end else if (wd_expired) begin
                    out_valid_d   = 1'b1;
                    out_err_d     = 1'b1;
                    out_product_d = '0;
                    out_tag_d     = tag_q;
                    state_d       = RST_MUL;
                end
            end
            default: begin
                state_d = RST_MUL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RST_MUL;
            wd_q          <= '0;
            mul_m_q       <= '0;
            mul_r_q       <= '0;
            tag_q         <= '0;
            out_valid_q   <= 1'b0;
            out_err_q     <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            mul_m_q       <= mul_m_d;
            mul_r_q       <= mul_r_d;
            tag_q         <= tag_d;
            out_valid_q   <= out_valid_d;
            out_err_q     <= out_err_d;
            out_product_q <= out_product_d;
            out_tag_q     <= out_tag_d;
        end
    end

    assign bus.in_ready    = !fifo_full;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_err     = out_err_q;
    assign bus.out_product = out_product_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.mul_m       = mul_m_q;
    assign bus.mul_r       = mul_r_q;
    assign bus.mul_load    = (state_q == LOAD);
    // RST_MUL is the reset state, so the multiplier reset follows the async reset directly.
    assign bus.mul_reset   = (state_q == RST_MUL);
    assign bus.busy        = ((state_q != IDLE) && (state_q != RST_MUL)) || !fifo_empty;

endmodule

// File: tb/tb_booth_issue.sv
// Directed bench for booth_issue with a cycle-accurate behavioural Booth multiplier
// (done falls 2 cycles after load, rises Y+3 cycles after load; can be made to hang).
module tb_booth_issue;
    import booth_pkg::*;

    localparam int X      = 32;
    localparam int Y      = 32;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int WD_CYC = Y + 16;

    logic clk = 1'b0;
    logic reset;
    logic hang_arm;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    booth_issue_if #(.X(X), .Y(Y), .TAG_W(TAG_W)) bus ();

    booth_issue #(
        .X      (X),
        .Y      (Y),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .WD_CYC (WD_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier
    logic               mdl_act;
    int                 mdl_cnt;
    logic               done_r;
    logic [63:0]        prod_r;
    logic signed [63:0] ma, rb;

    assign ma = {{32{bus.mul_m[31]}}, bus.mul_m};
    assign rb = {{32{bus.mul_r[31]}}, bus.mul_r};
    assign bus.mul_done    = done_r;
    assign bus.mul_product = prod_r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_act <= 1'b0;
            mdl_cnt <= 0;
            done_r  <= 1'b1;
            prod_r  <= '0;
        end else if (bus.mul_reset) begin
            mdl_act <= 1'b0;
            mdl_cnt <= 0;
            done_r  <= 1'b1;
        end else if (bus.mul_load) begin
            mdl_act <= !hang_arm;
            mdl_cnt <= 0;
        end else if (mdl_act) begin
            mdl_cnt <= mdl_cnt + 1;
            if (mdl_cnt == 0) done_r <= 1'b0;
            if (mdl_cnt == Y + 1) begin
                done_r  <= 1'b1;
                mdl_act <= 1'b0;
                prod_r  <= ma * rb;
            end
        end
    end

    function automatic booth_op_t mk_op(input logic [31:0] m, input logic [31:0] r,
                                        input logic [3:0] tag);
        booth_op_t o;
        o.m   = m;
        o.r   = r;
        o.tag = tag;
        return o;
    endfunction

    // Starts and ends at a negedge; acc is the index of the accepting posedge.
    task automatic push(input booth_op_t op, output int acc);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_m     = op.m;
        bus.in_r     = op.r;
        bus.in_tag   = op.tag;
        while (bus.in_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL push_tag%0d: in_ready got %b required 1 (timeout)", op.tag, bus.in_ready);
            acc = -1;
        end else begin
            acc = cyc + 1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Starts and ends at a negedge with out_ready high; seen is the posedge that registered the result.
    task automatic collect(input logic [63:0] exp_p, input logic [3:0] exp_tag,
                           input logic exp_err, input string nm, output int seen);
        int w = 0;
        while (bus.out_valid !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        seen = cyc;
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_valid: got %b required 1 (timeout)", nm, bus.out_valid);
        end else begin
            total++;
            if (bus.out_product !== exp_p) begin
                bad++;
                $display("FAIL %s_product: got %h required %h", nm, bus.out_product, exp_p);
            end
            total++;
            if (bus.out_tag !== exp_tag) begin
                bad++;
                $display("FAIL %s_tag: got %0d required %0d", nm, bus.out_tag, exp_tag);
            end
            total++;
            if (bus.out_err !== exp_err) begin
                bad++;
                $display("FAIL %s_err: got %b required %b", nm, bus.out_err, exp_err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
        total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err: got %b required 0", bus.out_err); end
        total++; if (bus.mul_load !== 1'b0) begin bad++; $display("FAIL rst_mul_load: got %b required 0", bus.mul_load); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        total++; if (bus.out_product !== 64'h0) begin bad++; $display("FAIL rst_out_product: got %h required 0", bus.out_product); end
        total++; if (bus.out_tag !== 4'h0) begin bad++; $display("FAIL rst_out_tag: got %h required 0", bus.out_tag); end
        total++; if (bus.mul_m !== 32'h0) begin bad++; $display("FAIL rst_mul_m: got %h required 0", bus.mul_m); end
        total++; if (bus.mul_r !== 32'h0) begin bad++; $display("FAIL rst_mul_r: got %h required 0", bus.mul_r); end
        total++; if (bus.mul_reset !== 1'b1) begin bad++; $display("FAIL rst_mul_reset: got %b required 1", bus.mul_reset); end
        reset = 1'b0;
        #1;
        total++; if (bus.mul_reset !== 1'b1) begin bad++; $display("FAIL rst_release_mul_reset: got %b required 1", bus.mul_reset); end
        @(negedge clk);
        total++; if (bus.mul_reset !== 1'b0) begin bad++; $display("FAIL rst_after_edge_mul_reset: got %b required 0", bus.mul_reset); end
        $display("test_reset done");
    endtask

    task automatic test_single_op();
        int acc, seen;
        bus.out_ready = 1'b1;
        push(mk_op(32'd3, 32'd5, 4'd1), acc);
        collect(64'd15, 4'd1, 1'b0, "single", seen);
        total++;
        if (seen - acc + 1 != Y + 6) begin
            bad++;
            $display("FAIL single_latency: got %0d required %0d", seen - acc + 1, Y + 6);
        end
        $display("test_single_op: latency=%0d", seen - acc + 1);
    endtask

    task automatic test_signed();
        int acc, seen;
        push(mk_op(32'hFFFF_FFF9, 32'd6, 4'd2), acc);
        collect(64'hFFFF_FFFF_FFFF_FFD6, 4'd2, 1'b0, "signed_neg7x6", seen);
        push(mk_op(32'h8000_0000, 32'hFFFF_FFFF, 4'd3), acc);
        collect(64'h0000_0000_8000_0000, 4'd3, 1'b0, "signed_min_x_neg1", seen);
        $display("test_signed done");
    endtask

    task automatic test_back_to_back();
        int a0, a1, s0, s1;
        push(mk_op(32'd100, 32'd200, 4'd4), a0);
        push(mk_op(32'hFFFF_FFFD, 32'hFFFF_FFF7, 4'd5), a1);
        collect(64'd20000, 4'd4, 1'b0, "b2b_first", s0);
        collect(64'd27, 4'd5, 1'b0, "b2b_second", s1);
        total++;
        if (s1 - s0 != Y + 5) begin
            bad++;
            $display("FAIL b2b_interval: got %0d required %0d", s1 - s0, Y + 5);
        end
        $display("test_back_to_back: interval=%0d", s1 - s0);
    endtask

    task automatic test_backpressure();
        logic [63:0] bp_exp [6] = '{64'd10, 64'd20, 64'd30, 64'd40, 64'd50, 64'd60};
        int a, s, w;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(mk_op(32'(i + 1), 32'd10, 4'(i)), a);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready: got %b required 0", bus.in_ready); end
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        repeat (5) @(negedge clk);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got %b required 1", bus.out_valid); end
        total++; if (bus.out_product !== 64'd10) begin bad++; $display("FAIL bp_hold_product: got %h required %h", bus.out_product, 64'd10); end
        total++; if (bus.out_tag !== 4'd0) begin bad++; $display("FAIL bp_hold_tag: got %0d required 0", bus.out_tag); end
        bus.out_ready = 1'b1;
        fork
            push(mk_op(32'd6, 32'd10, 4'd5), a);
            for (int i = 0; i < 6; i++) collect(bp_exp[i], 4'(i), 1'b0, "bp", s);
        join
        $display("test_backpressure done");
    endtask

    task automatic test_push_pop();
        int a, s, w;
        bus.out_ready = 1'b0;
        push(mk_op(32'd2, 32'd2, 4'd6), a);
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        push(mk_op(32'd1, 32'd1, 4'd7), a);
        push(mk_op(32'd1, 32'd2, 4'd8), a);
        push(mk_op(32'd1, 32'd3, 4'd9), a);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL pp_depth_m1_in_ready: got %b required 1", bus.in_ready); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL pp_busy: got %b required 1", bus.busy); end
        total++; if (bus.out_product !== 64'd4) begin bad++; $display("FAIL pp_held_product: got %h required %h", bus.out_product, 64'd4); end
        total++; if (bus.out_tag !== 4'd6) begin bad++; $display("FAIL pp_held_tag: got %0d required 6", bus.out_tag); end
        // Same edge: accept tag 10 while the freed output slot lets the FSM pop tag 7.
        bus.in_valid  = 1'b1;
        bus.in_m      = 32'd1;
        bus.in_r      = 32'd4;
        bus.in_tag    = 4'd10;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL pp_after_in_ready: got %b required 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL pp_after_out_valid: got %b required 0", bus.out_valid); end
        total++; if (bus.mul_load !== 1'b1) begin bad++; $display("FAIL pp_launch_load: got %b required 1", bus.mul_load); end
        collect(64'd1, 4'd7, 1'b0, "pp_a", s);
        collect(64'd2, 4'd8, 1'b0, "pp_b", s);
        collect(64'd3, 4'd9, 1'b0, "pp_c", s);
        collect(64'd4, 4'd10, 1'b0, "pp_d", s);
        $display("test_push_pop done");
    endtask

    task automatic test_watchdog();
        int a0, a1, s, w, lat;
        bus.out_ready = 1'b1;
        hang_arm = 1'b1;
        push(mk_op(32'd5, 32'd5, 4'd11), a0);
        push(mk_op(32'd7, 32'd3, 4'd12), a1);
        w = 0;
        while (bus.mul_load !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        hang_arm = 1'b0;
        w = 0;
        while (bus.out_valid !== 1'b1 && w < WD_CYC + 50) begin @(negedge clk); w++; end
        lat = cyc - a0 + 1;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL wd_valid: got %b required 1 (timeout)", bus.out_valid); end
        total++; if (bus.out_err !== 1'b1) begin bad++; $display("FAIL wd_err: got %b required 1", bus.out_err); end
        total++; if (bus.out_product !== 64'h0) begin bad++; $display("FAIL wd_product: got %h required 0", bus.out_product); end
        total++; if (bus.out_tag !== 4'd11) begin bad++; $display("FAIL wd_tag: got %0d required 11", bus.out_tag); end
        total++; if (bus.mul_reset !== 1'b1) begin bad++; $display("FAIL wd_mul_reset_pulse: got %b required 1", bus.mul_reset); end
        total++;
        if (lat < WD_CYC || lat > WD_CYC + 8) begin
            bad++;
            $display("FAIL wd_latency: got %0d required %0d..%0d", lat, WD_CYC, WD_CYC + 8);
        end
        @(negedge clk);
        total++; if (bus.mul_reset !== 1'b0) begin bad++; $display("FAIL wd_mul_reset_end: got %b required 0", bus.mul_reset); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL wd_consumed: got %b required 0", bus.out_valid); end
        collect(64'd21, 4'd12, 1'b0, "wd_next", s);
        $display("test_watchdog: err latency=%0d", lat);
    endtask

    task automatic test_reset_mid();
        int a, s, stale;
        bus.out_ready = 1'b1;
        push(mk_op(32'd9, 32'd9, 4'd13), a);
        push(mk_op(32'd9, 32'd9, 4'd14), a);
        push(mk_op(32'd9, 32'd9, 4'd15), a);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b required 1", bus.busy); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b required 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b required 1", bus.in_ready); end
        total++; if (bus.mul_reset !== 1'b1) begin bad++; $display("FAIL mid_mul_reset: got %b required 1", bus.mul_reset); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b required 0", bus.busy); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.mul_reset !== 1'b1) begin bad++; $display("FAIL mid_release_mul_reset: got %b required 1", bus.mul_reset); end
        @(negedge clk);
        total++; if (bus.mul_reset !== 1'b0) begin bad++; $display("FAIL mid_after_edge_mul_reset: got %b required 0", bus.mul_reset); end
        stale = 0;
        repeat (3 * (Y + 6)) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL mid_stale_results: got %0d required 0", stale); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_idle_busy: got %b required 0", bus.busy); end
        push(mk_op(32'd4, 32'd4, 4'd1), a);
        collect(64'd16, 4'd1, 1'b0, "mid_recover", s);
        $display("test_reset_mid done");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_m      = '0;
        bus.in_r      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        hang_arm      = 1'b0;
        reset         = 1'b0;
        test_reset();
        test_single_op();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_push_pop();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_issue.md
# booth_issue

Issue/collect sequencer that sits directly upstream and downstream of the Booth FSM multiplier. It accepts tagged signed operand pairs over a valid/ready stream and buffers them in a small FIFO. It launches one multiplication at a time by driving the multiplier's `m`/`r`/`load`/`reset` inputs, detects completion from the multiplier's `done`/`product` outputs, and returns the tagged product over a valid/ready stream. A watchdog recovers from a hung multiplier.

## Interface
- `X`, default 32: multiplicand width (`m`).
- `Y`, default 32: multiplier width (`r`).
- `DEPTH`, default 4: operand FIFO entries, power of 2, ≥2.
- `TAG_W`, default 4: tag width.
- `WD_CYC`, default `Y+16`: watchdog limit in cycles.

Ports:
- `clk` in 1: clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1, `in_ready` out 1: operand handshake.
- `in_m` in X, `in_r` in Y: two's-complement operands.
- `in_tag` in TAG_W: caller tag.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_product` out X+Y: signed product.
- `out_tag` out TAG_W: tag of the result.
- `out_err` out 1: result flagged invalid (watchdog fired).
- `mul_m` out X, `mul_r` out Y, `mul_load` out 1, `mul_reset` out 1: to the multiplier.
- `mul_product` in X+Y, `mul_done` in 1: from the multiplier.
- `busy` out 1: FSM not in IDLE or FIFO non-empty.

## Operation
- Input is accepted on a cycle with `in_valid && in_ready`. `in_ready` = FIFO not full.
- FSM states and transitions:
  - RST_MUL: `mul_reset`=1 for one cycle → IDLE.
  - IDLE: if FIFO non-empty and the output slot is free (`!out_valid || out_ready`), pop the FIFO and latch m/r/tag into `mul_m`/`mul_r`/tag registers → LOAD.
  - LOAD: `mul_load`=1 for exactly one cycle → WAIT_LO.
  - WAIT_LO: wait for `mul_done`==0 → WAIT_HI.
  - WAIT_HI: on `mul_done`==1, capture `mul_product` and the tag into the output register, set `out_valid`, clear `out_err` → IDLE.
- `mul_m`/`mul_r` hold stable from the LOAD cycle until the next pop. The multiplier reads `m` combinationally throughout the operation.
- Completion is edge-qualified (low then high). `mul_done` is already 1 when LOAD is issued and only falls 2 cycles later, so a level check would capture a stale product.
- Watchdog: counter cleared on entry to LOAD, incremented in WAIT_LO/WAIT_HI. When it reaches `WD_CYC`:
  - emit a result with `out_err`=1, `out_product`=0, the operation's tag;
  - → RST_MUL.
- The output register holds its value while `out_valid && !out_ready`.
- Push and pop in the same cycle are allowed. Push on a full FIFO and pop on an empty FIFO cannot occur (both are gated).
- Products are X+Y-bit two's complement, passed through unmodified.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`, `out_err`, `mul_load`, `busy` = 0.
  - `out_product`, `out_tag`, `mul_m`, `mul_r` = 0.
  - `mul_reset`=1; FSM in RST_MUL.
- After `reset` deasserts, `mul_reset` stays high for the first clock edge, then falls.
- Launch latency: accept at edge n → pop at edge n+1 (IDLE) → `mul_load` high during cycle n+2.
- Multiplier latency from `mul_load` to `mul_done` rising: Y+3 cycles. `out_valid` asserts the following cycle.
- Total: accept → `out_valid` = Y+6 cycles with the output free.
- Throughput: one operation per Y+5 cycles.
- Reset mid-operation (asynchronous):
  - FIFO emptied, output dropped.
  - `mul_reset` asserted immediately and held through the first edge after release.

## Structure
- Shared package `booth_pkg`:
  - `issue_state_t` enum {RST_MUL, IDLE, LOAD, WAIT_LO, WAIT_HI};
  - packed struct `booth_op_t` {m, r, tag};
  - default widths X=32, Y=32.
- One sub-module, `booth_op_fifo`:
  - parameterised by DEPTH and entry width;
  - pointers with an extra wrap bit for full/empty;
  - asynchronous reset.
- The FSM, watchdog and output register live in `booth_issue`.

## Test plan
- **Single op:** m=3, r=5, tag=1, `out_ready`=1 → `out_product`=15, `out_tag`=1, `out_err`=0, `out_valid` exactly Y+6 cycles after accept.
- **Signed:** m=-7, r=6 → `out_product`=64'hFFFF_FFFF_FFFF_FFD6 (-42). Also m=-2^31, r=-1 → 64'h0000_0000_8000_0000.
- **Backpressure/full:**
  - push 6 ops with `out_ready`=0 → `in_ready` falls after 5 accepts (one in flight, 4 queued);
  - the first result is held stable;
  - releasing `out_ready` → all 6 results return in order with correct tags.
- **Watchdog:** model holds `mul_done`=1 permanently → after `WD_CYC` cycles, a result with `out_err`=1 and the correct tag, one `mul_reset` pulse, then the next op completes normally.
- **Reset mid-op:** async `reset` during WAIT_LO with 2 ops queued → `out_valid`=0, `in_ready`=1, `mul_reset`=1 immediately; no stale result appears afterwards.
- **Simultaneous push/pop:** FIFO at DEPTH-1 with an accept and a pop on the same edge → occupancy unchanged, `in_ready` stays 1.
